// File: rtl/cordic_iter_engine.sv
// Iterative CORDIC engine: one micro-rotation per clock, rotation or vectoring mode,
// valid/ready on both sides, sticky per-operation overflow flags.
module cordic_iter_engine #(
    parameter int p_WIDTH      = 32,
    parameter int p_ITERATIONS = p_WIDTH - 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               mode,
    input  logic [p_WIDTH-1:0] x_in,
    input  logic [p_WIDTH-1:0] y_in,
    input  logic [p_WIDTH-1:0] z_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [p_WIDTH-1:0] x_out,
    output logic [p_WIDTH-1:0] y_out,
    output logic [p_WIDTH-1:0] z_out,
    output logic               xOverflow,
    output logic               yOverflow,
    output logic               zOverflow
);

    localparam int ITER_W   = (p_ITERATIONS < 2) ? 1 : $clog2(p_ITERATIONS);
    localparam int TBL_SIZE = 2 ** ITER_W;
    localparam int MSB      = p_WIDTH - 1;

    generate
        if (p_ITERATIONS < 1 || p_ITERATIONS > p_WIDTH - 1) begin : g_bad_param
            $error("cordic_iter_engine: p_ITERATIONS must be in 1..p_WIDTH-1");
        end
    endgenerate

    // Binary-angle arctangent, 2^(p_WIDTH-1) == pi, rounded to nearest.
    function automatic logic [p_WIDTH-1:0] atan_entry(input int i);
        real r;
        r = $atan(2.0 ** (-i)) / 3.14159265358979323846 * (2.0 ** (p_WIDTH - 1));
        return p_WIDTH'(longint'($floor(r + 0.5)));
    endfunction

    // Table padded to a power of two so the counter indexes it at full width.
    logic signed [p_WIDTH-1:0] atan_tbl [TBL_SIZE];

    generate
        for (genvar gi = 0; gi < TBL_SIZE; gi++) begin : g_atan
            if (gi < p_ITERATIONS) begin : g_used
                localparam logic [p_WIDTH-1:0] c_ATAN = atan_entry(gi);
                assign atan_tbl[gi] = c_ATAN;
            end else begin : g_pad
                assign atan_tbl[gi] = '0;
            end
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                    state_reg, state_next;
    logic                      mode_reg;
    logic [ITER_W-1:0]         iter_reg;
    logic signed [p_WIDTH-1:0] x_reg, y_reg, z_reg;
    logic                      x_ovf_reg, y_ovf_reg, z_ovf_reg;

    logic                      d_pos;
    logic                      last_iter;
    logic signed [p_WIDTH-1:0] x_sh, y_sh, atan_cur;
    logic signed [p_WIDTH-1:0] x_next, y_next, z_next;
    logic                      x_ovf, y_ovf, z_ovf;

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = S_RUN;
            end
            S_RUN: begin
                if (last_iter) state_next = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // d = +1 (d_pos) drives z toward zero in rotation, y toward zero in vectoring.
    always_comb begin
        d_pos     = mode_reg ? y_reg[MSB] : ~z_reg[MSB];
        last_iter = (iter_reg == ITER_W'(p_ITERATIONS - 1));
        x_sh      = x_reg >>> iter_reg;
        y_sh      = y_reg >>> iter_reg;
        atan_cur  = atan_tbl[iter_reg];
        x_next    = d_pos ? (x_reg - y_sh) : (x_reg + y_sh);
        y_next    = d_pos ? (y_reg + x_sh) : (y_reg - x_sh);
        z_next    = d_pos ? (z_reg - atan_cur) : (z_reg + atan_cur);
        // Subtraction overflows when operands differ in sign; addition when they agree.
        x_ovf     = ((x_reg[MSB] == y_sh[MSB]) ^ d_pos) && (x_next[MSB] != x_reg[MSB]);
        y_ovf     = ((y_reg[MSB] == x_sh[MSB]) ^ ~d_pos) && (y_next[MSB] != y_reg[MSB]);
        z_ovf     = ((z_reg[MSB] == atan_cur[MSB]) ^ d_pos) && (z_next[MSB] != z_reg[MSB]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            mode_reg  <= 1'b0;
            iter_reg  <= '0;
            x_reg     <= '0;
            y_reg     <= '0;
            z_reg     <= '0;
            x_ovf_reg <= 1'b0;
            y_ovf_reg <= 1'b0;
            z_ovf_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                S_IDLE: begin
                    if (in_valid) begin
                        mode_reg  <= mode;
                        iter_reg  <= '0;
                        x_reg     <= x_in;
                        y_reg     <= y_in;
                        z_reg     <= z_in;
                        x_ovf_reg <= 1'b0;
                        y_ovf_reg <= 1'b0;
                        z_ovf_reg <= 1'b0;
                    end
                end
                S_RUN: begin
                    x_reg     <= x_next;
                    y_reg     <= y_next;
                    z_reg     <= z_next;
                    iter_reg  <= iter_reg + ITER_W'(1);
                    x_ovf_reg <= x_ovf_reg | x_ovf;
                    y_ovf_reg <= y_ovf_reg | y_ovf;
                    z_ovf_reg <= z_ovf_reg | z_ovf;
                end
                default: ;
            endcase
        end
    end

    assign x_out     = x_reg;
    assign y_out     = y_reg;
    assign z_out     = z_reg;
    assign xOverflow = x_ovf_reg;
    assign yOverflow = y_ovf_reg;
    assign zOverflow = z_ovf_reg;

endmodule
